// File: rtl/debug7sd_pkg.sv
// Shared types and widths for the seven-segment debug display scheduler.
package debug7sd_pkg;

  localparam int SEG_VALUE_W = 32;
  localparam int SEG_MODE_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    ADVANCE,
    MANUAL
  } sched_state_t;

endpackage

// File: rtl/debug7sd_rr_pick.sv
// Combinational round-robin finder: first eligible index after start_i, wrapping,
// with start_i itself considered last so a lone eligible channel is reselected.
module debug7sd_rr_pick #(
  parameter int N_CH = 4,
  parameter int CH_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] eligible_i,
  input  logic [CH_W-1:0] start_i,
  output logic [CH_W-1:0] next_o,
  output logic            found_o
);

  int unsigned            idx;
  logic        [CH_W-1:0] idx_w;

  // Scan farthest-first so the nearest eligible candidate wins the final assignment.
  always_comb begin
    next_o  = start_i;
    found_o = 1'b0;
    idx     = 0;
    idx_w   = '0;
    for (int k = N_CH; k >= 1; k--) begin
      idx   = (int'(start_i) + k) % N_CH;
      idx_w = CH_W'(idx);
      if (eligible_i[idx_w]) begin
        next_o  = idx_w;
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/debug7sd_scheduler.sv
// Round-robin time-sharing of the 4-digit debug display among N_CH posting sources.
// Optional staleness timeout enabled by defining DEBUG7SD_SCHED_STALE_EN.
module debug7sd_scheduler
  import debug7sd_pkg::*;
#(
  parameter  int N_CH         = 4,
  parameter  int DWELL_CYCLES = 100_000_000,
  parameter  int STALE_CYCLES = 500_000_000,
  localparam int CH_W         = $clog2(N_CH)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_CH-1:0]             post_valid_i,
  input  logic [N_CH*SEG_VALUE_W-1:0] post_value_i,
  input  logic [N_CH*SEG_MODE_W-1:0]  post_mode_i,
  input  logic                        hold_i,
  input  logic                        manual_en_i,
  input  logic [CH_W-1:0]             manual_sel_i,
  output logic [SEG_VALUE_W-1:0]      disp_value_o,
  output logic [SEG_MODE_W-1:0]       disp_mode_o,
  output logic [CH_W-1:0]             cur_ch_o,
  output logic                        cur_valid_o,
  output logic [N_CH-1:0]             loaded_o,
  output logic [N_CH-1:0]             stale_o
);

  localparam int CNT_W = $clog2(DWELL_CYCLES);

  logic [SEG_VALUE_W-1:0] value_q [N_CH];
  logic [SEG_MODE_W-1:0]  mode_q  [N_CH];
  logic [N_CH-1:0]        loaded_q;
  logic [N_CH-1:0]        eligible;

  sched_state_t           state_q;
  logic [CH_W-1:0]        ptr_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [SEG_VALUE_W-1:0] disp_value_q;
  logic [SEG_MODE_W-1:0]  disp_mode_q;
  logic [CH_W-1:0]        cur_ch_q;
  logic                   cur_valid_q;

  logic [CH_W-1:0]        pick_next;
  logic                   pick_found;

  // Shadow registers: latest post per channel, posts during reset are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin
        value_q[i] <= '0;
        mode_q[i]  <= '0;
      end
      loaded_q <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (post_valid_i[i]) begin
          value_q[i]  <= post_value_i[SEG_VALUE_W*i +: SEG_VALUE_W];
          mode_q[i]   <= post_mode_i[SEG_MODE_W*i +: SEG_MODE_W];
          loaded_q[i] <= 1'b1;
        end
      end
    end
  end

`ifdef DEBUG7SD_SCHED_STALE_EN
  localparam int AGE_W = $clog2(STALE_CYCLES);

  logic [AGE_W-1:0] age_q [N_CH];
  logic [N_CH-1:0]  stale_q;

  // Age only counts once a channel holds data; it stops when stale is flagged.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) age_q[i] <= '0;
      stale_q <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (post_valid_i[i]) begin
          age_q[i]   <= '0;
          stale_q[i] <= 1'b0;
        end else if (loaded_q[i] && !stale_q[i]) begin
          if (age_q[i] == AGE_W'(STALE_CYCLES - 1)) stale_q[i] <= 1'b1;
          else                                      age_q[i]   <= age_q[i] + 1'b1;
        end
      end
    end
  end

  assign eligible = loaded_q & ~stale_q;
  assign stale_o  = stale_q;
`else
  assign eligible = loaded_q;
  assign stale_o  = '0;
`endif

  debug7sd_rr_pick #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_pick (
    .eligible_i (eligible),
    .start_i    (ptr_q),
    .next_o     (pick_next),
    .found_o    (pick_found)
  );

  // Scheduler FSM; outputs register from the shadow of the selected channel.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      cnt_q        <= '0;
      disp_value_q <= '0;
      disp_mode_q  <= '0;
      cur_ch_q     <= '0;
      cur_valid_q  <= 1'b0;
    end else if (manual_en_i) begin
      state_q      <= MANUAL;
      cur_ch_q     <= manual_sel_i;
      cur_valid_q  <= loaded_q[manual_sel_i];
      disp_value_q <= loaded_q[manual_sel_i] ? value_q[manual_sel_i] : '0;
      disp_mode_q  <= loaded_q[manual_sel_i] ? mode_q[manual_sel_i]  : '0;
    end else begin
      case (state_q)
        IDLE: begin
          disp_value_q <= '0;
          disp_mode_q  <= '0;
          cur_ch_q     <= '0;
          cur_valid_q  <= 1'b0;
          if (|eligible) begin
            // Search starts just past the last index so channel 0 is tried first.
            ptr_q   <= CH_W'(N_CH - 1);
            state_q <= ADVANCE;
          end
        end
        SHOW: begin
          disp_value_q <= value_q[ptr_q];
          disp_mode_q  <= mode_q[ptr_q];
          cur_ch_q     <= ptr_q;
          cur_valid_q  <= loaded_q[ptr_q];
          if (!hold_i) begin
            if (cnt_q == CNT_W'(DWELL_CYCLES - 1)) state_q <= ADVANCE;
            else                                   cnt_q   <= cnt_q + 1'b1;
          end
        end
        ADVANCE: begin
          if (pick_found) begin
            ptr_q   <= pick_next;
            cnt_q   <= '0;
            state_q <= SHOW;
          end else begin
            disp_value_q <= '0;
            disp_mode_q  <= '0;
            cur_ch_q     <= '0;
            cur_valid_q  <= 1'b0;
            state_q      <= IDLE;
          end
        end
        MANUAL: begin
          ptr_q   <= manual_sel_i;
          cnt_q   <= '0;
          state_q <= eligible[manual_sel_i] ? SHOW : ADVANCE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign disp_value_o = disp_value_q;
  assign disp_mode_o  = disp_mode_q;
  assign cur_ch_o     = cur_ch_q;
  assign cur_valid_o  = cur_valid_q;
  assign loaded_o     = loaded_q;

endmodule

// File: tb/tb_debug7sd_scheduler.sv
// Directed bench for debug7sd_scheduler with DWELL_CYCLES=8, STALE_CYCLES=40.
module tb_debug7sd_scheduler;

  localparam int N_CH = 4;
  localparam int CH_W = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [N_CH-1:0]   post_valid;
  logic [N_CH*32-1:0] post_value;
  logic [N_CH*4-1:0] post_mode;
  logic              hold;
  logic              manual_en;
  logic [CH_W-1:0]   manual_sel;
  logic [31:0]       disp_value;
  logic [3:0]        disp_mode;
  logic [CH_W-1:0]   cur_ch;
  logic              cur_valid;
  logic [N_CH-1:0]   loaded;
  logic [N_CH-1:0]   stale;

  int n_tests = 0;
  int n_fail  = 0;

  debug7sd_scheduler #(
    .N_CH         (N_CH),
    .DWELL_CYCLES (8),
    .STALE_CYCLES (40)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .post_valid_i (post_valid),
    .post_value_i (post_value),
    .post_mode_i  (post_mode),
    .hold_i       (hold),
    .manual_en_i  (manual_en),
    .manual_sel_i (manual_sel),
    .disp_value_o (disp_value),
    .disp_mode_o  (disp_mode),
    .cur_ch_o     (cur_ch),
    .cur_valid_o  (cur_valid),
    .loaded_o     (loaded),
    .stale_o      (stale)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [31:0] exp_v [4];
  logic [3:0]  exp_m [4];
  logic [1:0]  exp_c [4];

  initial begin
    exp_v = '{32'h11, 32'h22, 32'h33, 32'h11};
    exp_m = '{4'h1, 4'h2, 4'h4, 4'h1};
    exp_c = '{2'd0, 2'd1, 2'd3, 2'd0};

    reset = 1'b1; post_valid = '0; post_value = '0; post_mode = '0;
    hold = 1'b0; manual_en = 1'b0; manual_sel = '0;
    tick(); tick();
    chk("rst_disp_value", disp_value, 32'h0);
    chk("rst_disp_mode", {28'h0, disp_mode}, 32'h0);
    chk("rst_cur_ch", {30'h0, cur_ch}, 32'h0);
    chk("rst_cur_valid", {31'h0, cur_valid}, 32'h0);
    chk("rst_loaded", {28'h0, loaded}, 32'h0);
    chk("rst_stale", {28'h0, stale}, 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("idle_disp_value", disp_value, 32'h0);
      chk("idle_cur_valid", {31'h0, cur_valid}, 32'h0);
    end

    // Single channel: first-post latency and self-reselection.
    post_valid = 4'b0100;
    post_value[64 +: 32] = 32'h0000BEEF;
    post_mode[8 +: 4] = 4'h3;
    tick();
    post_valid = '0;
    chk("ch2_loaded", {28'h0, loaded}, 32'h4);
    tick();
    chk("ch2_lat_k2", disp_value, 32'h0);
    tick();
    chk("ch2_lat_k3", disp_value, 32'h0);
    tick();
    chk("ch2_disp_value", disp_value, 32'hBEEF);
    chk("ch2_disp_mode", {28'h0, disp_mode}, 32'h3);
    chk("ch2_cur_ch", {30'h0, cur_ch}, 32'h2);
    for (int i = 0; i < 30; i++) begin
      tick();
      chk("ch2_stay_ch", {30'h0, cur_ch}, 32'h2);
      chk("ch2_stay_valid", {31'h0, cur_valid}, 32'h1);
    end

    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst2_loaded", {28'h0, loaded}, 32'h0);

    // Three simultaneous posts, rotation 0 -> 1 -> 3 -> 0, 9 cycles each.
    post_valid = 4'b1011;
    post_value = {32'h33, 32'h0, 32'h22, 32'h11};
    post_mode  = {4'h4, 4'h0, 4'h2, 4'h1};
    for (int k = 1; k <= 31; k++) begin
      tick();
      post_valid = '0;
      if (k >= 4) begin
        chk("rot_value", disp_value, exp_v[(k - 4) / 9]);
        chk("rot_mode", {28'h0, disp_mode}, {28'h0, exp_m[(k - 4) / 9]});
        chk("rot_ch", {30'h0, cur_ch}, {30'h0, exp_c[(k - 4) / 9]});
      end
    end
    for (int k = 32; k <= 42; k++) tick();

    // Re-post of the displayed channel shows two cycles later.
    post_valid = 4'b0010;
    post_value[32 +: 32] = 32'h99;
    tick();
    post_valid = '0;
    chk("repost_k43", disp_value, 32'h22);
    tick();
    chk("repost_value", disp_value, 32'h99);
    chk("repost_ch", {30'h0, cur_ch}, 32'h1);

    // Hold for 20 cycles with dwell count 5; three SHOW cycles remain afterwards.
    hold = 1'b1;
    for (int k = 45; k <= 64; k++) begin
      tick();
      chk("hold_ch", {30'h0, cur_ch}, 32'h1);
    end
    hold = 1'b0;
    for (int k = 65; k <= 68; k++) begin
      tick();
      chk("resume_ch", {30'h0, cur_ch}, 32'h1);
    end
    tick();
    chk("resume_next_ch", {30'h0, cur_ch}, 32'h3);
    chk("resume_next_value", disp_value, 32'h33);

    // Manual on an unloaded channel, then release searches on from it.
    manual_en = 1'b1;
    manual_sel = 2'd2;
    for (int k = 70; k <= 73; k++) begin
      tick();
      chk("man2_ch", {30'h0, cur_ch}, 32'h2);
      chk("man2_valid", {31'h0, cur_valid}, 32'h0);
      chk("man2_value", disp_value, 32'h0);
    end
    manual_en = 1'b0;
    tick();
    chk("man2_rel_k74", {30'h0, cur_ch}, 32'h2);
    tick();
    chk("man2_rel_k75", {30'h0, cur_ch}, 32'h2);
    tick();
    chk("man2_rel_ch", {30'h0, cur_ch}, 32'h3);
    chk("man2_rel_value", disp_value, 32'h33);
    chk("man2_rel_valid", {31'h0, cur_valid}, 32'h1);

    // Manual on a loaded channel; release resumes SHOW there with a fresh dwell.
    manual_en = 1'b1;
    manual_sel = 2'd0;
    tick();
    chk("man0_value", disp_value, 32'h11);
    chk("man0_mode", {28'h0, disp_mode}, 32'h1);
    chk("man0_ch", {30'h0, cur_ch}, 32'h0);
    manual_en = 1'b0;
    for (int k = 78; k <= 87; k++) begin
      tick();
      chk("man0_dwell_ch", {30'h0, cur_ch}, 32'h0);
    end
    tick();
    chk("man0_next_ch", {30'h0, cur_ch}, 32'h1);
    chk("man0_next_value", disp_value, 32'h99);

    // Reset mid-operation drops a coincident post.
    reset = 1'b1;
    post_valid = 4'b1111;
    post_value = {4{32'h55}};
    tick();
    reset = 1'b0;
    post_valid = '0;
    chk("mrst_value", disp_value, 32'h0);
    chk("mrst_ch", {30'h0, cur_ch}, 32'h0);
    chk("mrst_valid", {31'h0, cur_valid}, 32'h0);
    chk("mrst_loaded", {28'h0, loaded}, 32'h0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mrst_after_valid", {31'h0, cur_valid}, 32'h0);
      chk("mrst_after_loaded", {28'h0, loaded}, 32'h0);
    end

`ifdef DEBUG7SD_SCHED_STALE_EN
    // ch1 goes silent and times out; ch0 keeps posting every 10 cycles.
    post_valid = 4'b0011;
    post_value = {32'h0, 32'h0, 32'hB1, 32'hA0};
    post_mode  = '0;
    for (int k = 1; k <= 80; k++) begin
      tick();
      post_valid = '0;
      if (k % 10 == 0) post_valid = 4'b0001;
      if (k == 40) chk("stale_k40", {28'h0, stale}, 32'h0);
      if (k == 41) chk("stale_k41", {28'h0, stale}, 32'h2);
      if (k >= 45) chk("stale_rot_ch", {30'h0, cur_ch}, 32'h0);
    end
    post_valid = 4'b0010;
    tick();
    post_valid = '0;
    chk("stale_cleared", {28'h0, stale}, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/debug7sd_scheduler.md
# debug7sd_scheduler

Time-shares the board's single 4-digit seven-segment debug display between N_CH independent debug sources. Each source posts a 32-bit value and a 4-bit display mode whenever it likes. The block buffers the latest post per channel and rotates the display round-robin among loaded channels with a fixed dwell time. It sits directly upstream of the display driver and feeds its mode and value inputs; a manual override pins the display to one channel.

## Interface
Parameters:
- N_CH, 4: number of requester channels, 2..8.
- DWELL_CYCLES, 100_000_000: clk cycles each channel is shown (1 s at 100 MHz); must be ≥2.
- STALE_CYCLES, 500_000_000: staleness timeout; only used with DEBUG7SD_SCHED_STALE_EN.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  synchronous, active-high.
- post_valid  in  N_CH  one-cycle strobe per channel; always accepted.
- post_value  in  N_CH*32  flat; channel i occupies [32*i +: 32].
- post_mode  in  N_CH*4  flat; channel i occupies [4*i +: 4].
- hold  in  1  freezes the dwell counter; rotation pauses.
- manual_en  in  1  level; pins the display to manual_sel.
- manual_sel  in  CH_W  channel index; CH_W = $clog2(N_CH).
- disp_value  out  32  to display driver.
- disp_mode  out  4  to display driver.
- cur_ch  out  CH_W  channel currently shown.
- cur_valid  out  1  shown channel holds data.
- loaded  out  N_CH  channel has posted since reset.
- stale  out  N_CH  channel has timed out; all zero without the macro.

## Operation
- Per-channel shadow registers hold value, mode and loaded. A post_valid[i] edge writes the shadow and sets loaded[i]. Simultaneous posts on several channels are all captured.
- FSM states are IDLE, SHOW, ADVANCE and MANUAL.
- IDLE: no eligible channel. Outputs are disp_value=0, disp_mode=0, cur_ch=0, cur_valid=0. Leaves IDLE to ADVANCE on the cycle after any channel becomes eligible.
- SHOW: outputs track the shadow of cur_ch, so a re-post is visible without switching channels. The dwell counter increments each cycle unless hold=1. At DWELL_CYCLES-1 the FSM goes to ADVANCE.
- ADVANCE (exactly one cycle):
  - Picks the first eligible channel after cur_ch, modulo N_CH.
  - If cur_ch is the only eligible channel, it is reselected.
  - If no channel is eligible, goes to IDLE.
  - Otherwise goes to SHOW with the counter cleared.
- Eligible means loaded, and also not stale when the macro is enabled.
- MANUAL: entered from any state on the cycle after manual_en=1; has priority over hold.
  - cur_ch=manual_sel, tracked each cycle; eligibility is ignored.
  - An unloaded channel shows 0/0 with cur_valid=0.
  - On manual_en falling: go to SHOW on manual_sel if it is eligible, else to ADVANCE searching from manual_sel. The counter is cleared either way.
- Counter width is $clog2(DWELL_CYCLES). The counter never wraps; it is cleared on entry to SHOW.

## Timing
- All outputs are registered. Reset values: disp_value=0, disp_mode=0, cur_ch=0, cur_valid=0, loaded=0, stale=0, state IDLE.
- Post-to-display latency for the displayed channel is 2 cycles: shadow at edge N, output register at edge N+1.
- First post after reset appears on disp_value 4 cycles after the strobe: shadow → IDLE exit → ADVANCE → SHOW output.
- Channel switch: the last SHOW cycle is followed by 1 ADVANCE cycle, during which the outputs hold the old channel. The period per channel is DWELL_CYCLES+1.
- Reset mid-operation clears shadows, counters and state in one cycle. A post_valid coincident with reset is dropped.

## Configuration
- DEBUG7SD_SCHED_STALE_EN defined:
  - Per-channel saturating age counter, cleared on post.
  - stale[i]=1 once the age reaches STALE_CYCLES; cleared by the next post.
  - Stale channels are skipped in auto rotation but still shown in MANUAL.
- Not defined: no age counters; stale tied to 0; eligibility equals loaded.

## Structure
- debug7sd_pkg holds:
  - typedef enum sched_state_t {IDLE, SHOW, ADVANCE, MANUAL};
  - localparams SEG_VALUE_W=32 and SEG_MODE_W=4.
- Sub-module debug7sd_rr_pick: combinational round-robin next-eligible finder.
  - Inputs: eligible mask and start index.
  - Outputs: next index and found flag.
  - Reused later for other shared debug resources.

## Test plan
Benches use DWELL_CYCLES=8 and STALE_CYCLES=40.
- Reset, no posts for 50 cycles → disp_value=0, cur_valid=0, state IDLE throughout.
- Post ch2 value 0x0000BEEF mode 0x3 → disp_value=0xBEEF and disp_mode=3 four cycles later. cur_ch stays 2 across multiple dwells.
- Post ch0=0x11, ch1=0x22, ch3=0x33 in the same cycle → displayed sequence 0x11, 0x22, 0x33, 0x11, with each value held for 9 cycles.
- During ch1 dwell, re-post ch1=0x99 → disp_value=0x99 two cycles later, with no channel change.
- hold=1 for 20 cycles mid-dwell → cur_ch unchanged. Rotation resumes with the remaining dwell count.
- manual_en=1 with manual_sel=2 (unloaded) → disp 0, cur_valid=0. On release, ADVANCE goes to ch3.
- With the macro: ch0 and ch1 loaded, ch1 silent for 40 cycles → stale[1]=1 and rotation shows only ch0. Re-posting ch1 clears stale[1].
